// File: rtl/cntr_pkg.sv
// Shared constants and the response record for the controller response path.
package cntr_pkg;

    localparam int DQ        = 16;
    localparam int IDX       = 7;
    localparam int TAG_DEPTH = 8;
    localparam int RSP_DEPTH = 4;
    localparam int BL        = 8;
    localparam int BEAT_W    = $clog2(BL);

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef struct packed {
        logic           rtype;
        logic [IDX-1:0] idx;
        logic [DQ-1:0]  dq;
        logic           last;
    } rsp_t;

endpackage

// File: rtl/cntr_rsp_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module cntr_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
        rdata_o = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset; the consumer qualifies the head with empty_o.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/cntr_rsp_dp.sv
// Response datapath: tags issued reads, pairs PHY beats with them, merges write acks
// into a single valid/ready response stream.
module cntr_rsp_dp
    import cntr_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           iss_valid,
    input  logic           iss_type,
    input  logic [IDX-1:0] iss_idx,
    output logic           iss_ready,
    input  logic           rd_valid,
    input  logic [DQ-1:0]  rd_dq,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_type,
    output logic [IDX-1:0] rsp_idx,
    output logic [DQ-1:0]  rsp_dq,
    output logic           rsp_last,
    output logic           err_unexp,
    output logic           err_ovf
);

    logic              tag_push, tag_pop, tag_full, tag_empty;
    logic [IDX-1:0]    tag_head;
    logic              buf_push, buf_pop, buf_full, buf_empty;
    rsp_t              buf_wdata, buf_head;
    logic [$bits(rsp_t)-1:0] buf_head_raw;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              wack_q, wack_d;
    logic [IDX-1:0]    wack_idx_q, wack_idx_d;
    logic              err_unexp_q, err_unexp_d;
    logic              err_ovf_q, err_ovf_d;
    logic              hold_q, hold_d;
    logic              hold_wack_q, hold_wack_d;
    logic              beat_ok, beat_last, sel_wack, wack_send, iss_acc;

    cntr_rsp_fifo #(.WIDTH(IDX), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tag_push),
        .pop_i   (tag_pop),
        .wdata_i (iss_idx),
        .rdata_o (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    cntr_rsp_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .wdata_i (buf_wdata),
        .rdata_o (buf_head_raw),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    always_comb begin
        buf_head  = rsp_t'(buf_head_raw);
        iss_ready = (iss_type == READ) ? !tag_full : !wack_q;
        iss_acc   = iss_valid && iss_ready;
        tag_push  = iss_acc && (iss_type == READ);

        // Overflowed beats still count and pop, so later bursts stay aligned to their tags.
        beat_ok   = rd_valid && !tag_empty;
        beat_last = (beat_cnt_q == BEAT_W'(BL - 1));
        tag_pop   = beat_ok && beat_last;
        buf_push  = beat_ok && !buf_full;
        buf_wdata = '{rtype: READ, idx: tag_head, dq: rd_dq, last: beat_last};

        // A presented response keeps its source until accepted.
        rsp_valid = !buf_empty || wack_q;
        sel_wack  = hold_q ? hold_wack_q : buf_empty;
        buf_pop   = rsp_valid && rsp_ready && !sel_wack;
        wack_send = rsp_valid && rsp_ready && sel_wack;

        rsp_type = 1'b0;
        rsp_idx  = '0;
        rsp_dq   = '0;
        rsp_last = 1'b0;
        if (rsp_valid) begin
            if (sel_wack) begin
                rsp_type = WRITE;
                rsp_idx  = wack_idx_q;
                rsp_last = 1'b1;
            end else begin
                rsp_type = buf_head.rtype;
                rsp_idx  = buf_head.idx;
                rsp_dq   = buf_head.dq;
                rsp_last = buf_head.last;
            end
        end

        beat_cnt_d  = beat_ok ? (beat_last ? '0 : beat_cnt_q + BEAT_W'(1)) : beat_cnt_q;
        wack_d      = wack_q;
        wack_idx_d  = wack_idx_q;
        if (wack_send) wack_d = 1'b0;
        if (iss_acc && (iss_type == WRITE)) begin
            wack_d     = 1'b1;
            wack_idx_d = iss_idx;
        end
        err_unexp_d = err_unexp_q || (rd_valid && tag_empty);
        err_ovf_d   = err_ovf_q || (beat_ok && buf_full);
        hold_d      = rsp_valid && !rsp_ready;
        hold_wack_d = sel_wack;

        err_unexp = err_unexp_q;
        err_ovf   = err_ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            wack_q      <= 1'b0;
            wack_idx_q  <= '0;
            err_unexp_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            hold_q      <= 1'b0;
            hold_wack_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            wack_q      <= wack_d;
            wack_idx_q  <= wack_idx_d;
            err_unexp_q <= err_unexp_d;
            err_ovf_q   <= err_ovf_d;
            hold_q      <= hold_d;
            hold_wack_q <= hold_wack_d;
        end
    end

endmodule

// File: tb/tb_cntr_rsp_dp.sv
// Bench for cntr_rsp_dp: directed scenarios plus random traffic against a queue-based model.
module tb_cntr_rsp_dp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_valid, iss_type, iss_ready;
    logic [6:0]  iss_idx;
    logic        rd_valid;
    logic [15:0] rd_dq;
    logic        rsp_valid, rsp_ready, rsp_type, rsp_last;
    logic [6:0]  rsp_idx;
    logic [15:0] rsp_dq;
    logic        err_unexp, err_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state: transaction-level queues.
    logic [24:0] m_buf[$];
    logic [6:0]  m_tags[$];
    int          m_beat;
    logic        m_wack;
    logic [6:0]  m_wack_idx;
    logic        m_eu, m_eo;
    int          m_cur;

    logic [28:0] obs;
    assign obs = {iss_ready, rsp_valid, rsp_type, rsp_idx, rsp_dq, rsp_last, err_unexp, err_ovf};

    cntr_rsp_dp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_type  (iss_type),
        .iss_idx   (iss_idx),
        .iss_ready (iss_ready),
        .rd_valid  (rd_valid),
        .rd_dq     (rd_dq),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_type  (rsp_type),
        .rsp_idx   (rsp_idx),
        .rsp_dq    (rsp_dq),
        .rsp_last  (rsp_last),
        .err_unexp (err_unexp),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [28:0] o, input logic [28:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk_bit(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic model_clear();
        m_buf.delete();
        m_tags.delete();
        m_beat = 0;
        m_wack = 1'b0;
        m_wack_idx = '0;
        m_eu = 1'b0;
        m_eo = 1'b0;
        m_cur = 0;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0;
        iss_type  = 1'b1;
        iss_idx   = '0;
        rd_valid  = 1'b0;
        rd_dq     = '0;
    endtask

    // Compare outputs mid-cycle, then advance model and DUT across one rising edge.
    task automatic tick(input string tag);
        logic [28:0] e;
        logic        er, pre_full, last;
        int          src;
        @(negedge clk);
        er  = iss_type ? (m_tags.size() < 8) : !m_wack;
        src = m_cur;
        if (src == 0) src = (m_buf.size() > 0) ? 1 : (m_wack ? 2 : 0);
        e = {er, 28'b0};
        if (src == 1) begin
            e[27]   = 1'b1;
            e[26:2] = m_buf[0];
        end else if (src == 2) begin
            e[27]   = 1'b1;
            e[26:2] = {1'b0, m_wack_idx, 16'h0000, 1'b1};
        end
        e[1] = m_eu;
        e[0] = m_eo;
        chk(tag, obs, e);
        pre_full = (m_buf.size() >= 4);
        @(posedge clk);
        if (e[27] && rsp_ready) begin
            if (src == 1) void'(m_buf.pop_front());
            else m_wack = 1'b0;
            m_cur = 0;
        end else if (e[27]) begin
            m_cur = src;
        end
        if (rd_valid) begin
            if (m_tags.size() == 0) begin
                m_eu = 1'b1;
            end else begin
                last = (m_beat == 7);
                if (!pre_full) m_buf.push_back({1'b1, m_tags[0], rd_dq, last});
                else m_eo = 1'b1;
                m_beat = (m_beat + 1) % 8;
                if (last) void'(m_tags.pop_front());
            end
        end
        if (iss_valid && er) begin
            if (iss_type) m_tags.push_back(iss_idx);
            else begin
                m_wack = 1'b1;
                m_wack_idx = iss_idx;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        model_clear();
        chk("reset", obs, {1'b1, 28'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic t, input int idx, input string tag);
        iss_valid = 1'b1;
        iss_type  = t;
        iss_idx   = 7'(idx);
        tick(tag);
        iss_valid = 1'b0;
        iss_type  = 1'b1;
    endtask

    task automatic beats(input int n, input int base, input string tag);
        for (int i = 0; i < n; i++) begin
            rd_valid = 1'b1;
            rd_dq    = 16'(base + i);
            tick(tag);
        end
        rd_valid = 1'b0;
    endtask

    task automatic idles(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        idle_inputs();
        rsp_ready = 1'b1;
        model_clear();
        do_reset();

        // Single read, one burst.
        issue(1'b1, 5, "rd5_issue");
        beats(8, 16'h1000, "rd5_beats");
        idles(3, "rd5_drain");

        // Three back-to-back reads, 24 beats.
        issue(1'b1, 1, "rd123_issue");
        issue(1'b1, 2, "rd123_issue");
        issue(1'b1, 3, "rd123_issue");
        beats(24, 16'h2000, "rd123_beats");
        idles(3, "rd123_drain");

        // Stray beat with no tag outstanding.
        beats(1, 16'hdead, "unexp_beat");
        idles(2, "unexp_after");
        chk_bit("err_unexp_sticky", err_unexp, 1'b1);
        chk_bit("unexp_no_rsp", rsp_valid, 1'b0);
        do_reset();

        // Fill the tag FIFO.
        for (int i = 0; i < 8; i++) issue(1'b1, 10 + i, "tagfill_issue");
        iss_valid = 1'b1;
        iss_type  = 1'b1;
        iss_idx   = 7'd99;
        #1;
        chk_bit("tag_full_refuse", iss_ready, 1'b0);
        tick("tagfill_refused");
        iss_valid = 1'b0;
        beats(8, 16'h3000, "tagfill_burst0");
        chk_bit("tag_ready_again", iss_ready, 1'b1);
        beats(56, 16'h3100, "tagfill_rest");
        idles(3, "tagfill_drain");

        // Write ack waits behind a read stream; second write refused while pending.
        issue(1'b1, 9, "wr_rd_issue");
        for (int i = 0; i < 8; i++) begin
            rd_valid  = 1'b1;
            rd_dq     = 16'(16'h4000 + i);
            iss_valid = (i == 1) || (i == 3);
            iss_type  = 1'b0;
            iss_idx   = (i == 1) ? 7'h7f : 7'h11;
            if (i == 3) begin
                #1;
                chk_bit("wr_refused", iss_ready, 1'b0);
            end
            tick("wr_stream");
        end
        idle_inputs();
        idles(2, "wr_drain");
        chk_bit("wack_sent", rsp_valid, 1'b0);
        issue(1'b0, 7'h11, "wr2_issue");
        idles(2, "wr2_drain");

        // Overflow with rsp_ready low, then the next read must map to its own burst.
        do_reset();
        rsp_ready = 1'b0;
        issue(1'b1, 20, "ovf_issue");
        beats(8, 16'h5000, "ovf_beats");
        chk_bit("err_ovf_set", err_ovf, 1'b1);
        issue(1'b1, 21, "ovf_next_issue");
        rsp_ready = 1'b1;
        idles(5, "ovf_drain");
        beats(8, 16'h6000, "ovf_next_beats");
        idles(3, "ovf_next_drain");

        // Random traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_type  = 1'($urandom_range(0, 1));
            iss_idx   = 7'($urandom);
            rd_valid  = 1'($urandom_range(0, 1));
            rd_dq     = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick("random");
        end
        idle_inputs();
        rsp_ready = 1'b1;

        // Reset in the middle of a burst, then a clean burst.
        do_reset();
        issue(1'b1, 30, "mid_issue");
        beats(3, 16'h7000, "mid_beats");
        do_reset();
        issue(1'b1, 31, "post_issue");
        beats(8, 16'h8000, "post_beats");
        idles(3, "post_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
